// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the reduced RISC-V core (ADDI, BNE) with a variable-latency fetch handshake.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] instr,
  input  logic             EQ,
  output logic             ir_en,
  output logic             pc_en,
  output logic             RegWrite,
  output logic             ALUctrl,
  output logic             ALUsrc,
  output logic             ImmSrc,
  output logic             PCsrc,
  output logic             retired,
  output logic             trap
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EX_ADDI = 3'd3;
  localparam logic [2:0] S_EX_BNE  = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  // Only opcode and funct3 steer the sequencer; the rest of IR feeds the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[WIDTH-1:15], ir_q[11:7]};

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    RegWrite = 1'b0;
    ALUctrl  = 1'b0;
    ALUsrc   = 1'b0;
    ImmSrc   = 1'b0;
    PCsrc    = 1'b0;
    retired  = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        // run is not looked at here so a started fetch always completes.
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[6:0] == OP_IMM && ir_q[14:12] == 3'b000)
          state_d = S_EX_ADDI;
        else if (ir_q[6:0] == OP_BRANCH && ir_q[14:12] == 3'b001)
          state_d = S_EX_BNE;
        else
          state_d = S_TRAP;
      end
      S_EX_ADDI: begin
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
        pc_en    = 1'b1;
        retired  = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_EX_BNE: begin
        ALUctrl = 1'b1;
        ImmSrc  = 1'b1;
        pc_en   = 1'b1;
        PCsrc   = ~EQ;
        retired = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
    if (retired) instr_cnt_d = instr_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are queued with the stimulus.
// Counter checks are included when PERF_CNT_EN is defined.
module tb_multicycle_ctrl;
  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 32;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BNE  = 32'hFE209EE3;
  localparam logic [31:0] I_BAD  = 32'h00000033;

  // {imem_req, ir_en, pc_en, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, retired, trap}
  localparam logic [9:0] E_IDLE   = 10'b00_0000_0000;
  localparam logic [9:0] E_FETCH  = 10'b10_0000_0000;
  localparam logic [9:0] E_FRDY   = 10'b11_0000_0000;
  localparam logic [9:0] E_DEC    = 10'b00_0000_0000;
  localparam logic [9:0] E_ADDI   = 10'b00_1101_0010;
  localparam logic [9:0] E_BNE_NE = 10'b00_1010_1110;
  localparam logic [9:0] E_BNE_EQ = 10'b00_1010_1010;
  localparam logic [9:0] E_TRAP   = 10'b00_0000_0001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             imem_req;
  logic             imem_ready;
  logic [WIDTH-1:0] instr;
  logic             EQ;
  logic             ir_en, pc_en, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, retired, trap;
`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .instr      (instr),
    .EQ         (EQ),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .RegWrite   (RegWrite),
    .ALUctrl    (ALUctrl),
    .ALUsrc     (ALUsrc),
    .ImmSrc     (ImmSrc),
    .PCsrc      (PCsrc),
    .retired    (retired),
    .trap       (trap)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {imem_req, ir_en, pc_en, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, retired, trap};

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  string      tag_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk();
    chk(tag_q.pop_front(), 32'(outs), 32'(exp_q.pop_front()));
  endtask

  // Drive one cycle of inputs, queue its expected outputs, check at negedge, return at posedge+1.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic eq,
                     input logic [31:0] ins, input logic [9:0] exp);
    run = r; imem_ready = rdy; EQ = eq; instr = ins;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    pop_chk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int cyc_exp, input int ins_exp);
`ifdef PERF_CNT_EN
    chk({tag, "_cyc"}, 32'(cycle_cnt), 32'(cyc_exp));
    chk({tag, "_ins"}, 32'(instr_cnt), 32'(ins_exp));
`else
    if (tag.len() < 0) $display("%0d %0d", cyc_exp, ins_exp);
`endif
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; imem_ready = 1'b1; EQ = 1'b0; instr = I_ADDI;
    @(posedge clk); #1;

    // Reset held with run=1: nothing requested, nothing enabled.
    cyc("rst0", 1, 1, 0, I_ADDI, E_IDLE);
    chk_cnt("rst", 0, 0);
    cyc("rst1", 1, 1, 0, I_ADDI, E_IDLE);
    rst_n = 1'b1;
    cyc("idle_after_rst", 1, 1, 0, I_ADDI, E_IDLE);

    // ADDI with immediate ready.
    cyc("addi_fetch", 1, 1, 0, I_ADDI, E_FRDY);
    cyc("addi_dec",   1, 0, 0, 32'h0, E_DEC);
    cyc("addi_ex",    1, 0, 0, 32'h0, E_ADDI);

    // BNE not taken-equal (EQ=0 -> branch), then EQ=1 (fall through).
    cyc("bne0_fetch", 1, 1, 0, I_BNE, E_FRDY);
    cyc("bne0_dec",   1, 0, 0, 32'h0, E_DEC);
    cyc("bne0_ex",    1, 0, 0, 32'h0, E_BNE_NE);
    cyc("bne1_fetch", 1, 1, 1, I_BNE, E_FRDY);
    cyc("bne1_dec",   1, 0, 1, 32'h0, E_DEC);
    cyc("bne1_ex",    1, 0, 1, 32'h0, E_BNE_EQ);

    // Memory stalls four cycles; request held, ir_en only on ready.
    for (int i = 0; i < 4; i++) cyc("stall_fetch", 1, 0, 0, I_BNE, E_FETCH);
    cyc("stall_rdy", 1, 1, 0, I_ADDI, E_FRDY);
    cyc("stall_dec", 1, 0, 0, 32'h0, E_DEC);
    cyc("stall_ex",  1, 0, 0, 32'h0, E_ADDI);
    chk_cnt("after4", 16, 4);

    // Reset asserted mid-fetch drops imem_req without a clock edge.
    cyc("pre_async", 1, 0, 0, I_ADDI, E_FETCH);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(E_IDLE);
    tag_q.push_back("async_rst");
    pop_chk();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("idle_after_rst2", 1, 1, 0, I_BAD, E_IDLE);

    // Unsupported encoding traps and stays trapped regardless of run.
    cyc("bad_fetch", 1, 1, 0, I_BAD, E_FRDY);
    cyc("bad_dec",   1, 1, 0, I_ADDI, E_DEC);
    for (int i = 0; i < 4; i++) cyc("trap_sticky", i[0], 1, 0, I_ADDI, E_TRAP);
    chk_cnt("trap_hold", 2, 0);
    rst_n = 1'b0;
    cyc("trap_clr", 0, 0, 0, I_ADDI, E_IDLE);
    rst_n = 1'b1;

    // run dropped during fetch: instruction completes, then park in IDLE.
    cyc("park_idle", 1, 0, 0, I_ADDI, E_IDLE);
    cyc("drop_fetch", 0, 1, 0, I_ADDI, E_FRDY);
    cyc("drop_dec",   0, 0, 0, 32'h0, E_DEC);
    cyc("drop_ex",    0, 0, 0, 32'h0, E_ADDI);
    cyc("drop_idle0", 0, 1, 0, I_ADDI, E_IDLE);
    chk_cnt("drop", 3, 1);
    cyc("drop_idle1", 0, 1, 0, I_ADDI, E_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
